// File: rtl/seg_pkg.sv
// Shared types and glyph table for the multiplexed BCD seven-segment display scanner.
package seg_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned BCD_W  = NIB_W * DIGITS;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic [NIB_W-1:0] d3;
        logic [NIB_W-1:0] d2;
        logic [NIB_W-1:0] d1;
        logic [NIB_W-1:0] d0;
    } bcd_word_t;

    // Active-low {g,f,e,d,c,b,a} glyphs; anything above 9 renders as a dash.
    function automatic logic [SEG_W-1:0] seg_glyph(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] g;
        case (nib)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = seg_glyph(nibble_i);
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Captures BCD results and scans them onto a 4-digit common-anode display,
// committing new values only at frame boundaries.
module bcd_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned GUARD_CYCLES = 1000,
    parameter bit          LZ_BLANK     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BCD_W-1:0]  bcd_in,
    input  logic              bcd_valid,
    output logic [DIGITS-1:0] an,
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic              frame_tick,
    output logic              digit_err
);

    localparam int unsigned CNT_MAX = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    scan_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    bcd_word_t          disp_q, disp_d;
    bcd_word_t          pend_q, pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               frame_tick_q, frame_tick_d;
    logic               digit_err_q, digit_err_d;
    logic               dp_q;

    logic [DIGITS-1:0][NIB_W-1:0] nib_c;
    logic [BCD_W-1:0]             disp_bits_c;
    logic [SEG_W-1:0]             dec_seg_c;
    logic                         blank_c;
    logic                         err_c;

    assign disp_bits_c = disp_q;
    assign nib_c       = disp_q;

    bcd_to_7seg u_dec (
        .nibble_i (nib_c[idx_q]),
        .seg_c    (dec_seg_c)
    );

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        blank_c = LZ_BLANK && (idx_q != '0)
                  && ((disp_bits_c >> {idx_q, 2'b00}) == '0);
    end

    always_comb begin
        err_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (nib_c[i] > 4'd9) err_c = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_flag_d  = pend_flag_q;
        an_d         = an_q;
        seg_d        = seg_q;
        frame_tick_d = 1'b0;
        digit_err_d  = err_c;

        case (state_q)
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    an_d    = DIGITS'(~(4'b0001 << idx_q));
                    seg_d   = blank_c ? SEG_BLANK : dec_seg_c;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    an_d    = '1;
                    seg_d   = SEG_BLANK;
                    // Wrapping back to digit 0 starts a frame: commit the pending value.
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        frame_tick_d = 1'b1;
                        if (pend_flag_q) begin
                            disp_d      = pend_q;
                            pend_flag_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase

        // Capture after commit so a strobe on the commit edge stays pending.
        if (bcd_valid) begin
            pend_d      = bcd_in;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_GUARD;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_flag_q  <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
            digit_err_q  <= 1'b0;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
            digit_err_q  <= digit_err_d;
            dp_q         <= 1'b1;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;
    assign digit_err  = digit_err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: time-based display model plus directed literal checks and random strobes.
module tb_bcd_display_scan;

    localparam int G     = 2;
    localparam int D     = 4;
    localparam int SLOT  = G + D;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    logic        digit_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles since reset, committed value, pending value, registered error flag.
    int          m_t    = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_flag = 1'b0;
    bit          m_err  = 1'b0;
    bit          chk_en = 1'b0;
    bit          watch_one = 1'b0;
    bit          saw_one   = 1'b0;

    always #5 clk = ~clk;

    bcd_display_scan #(
        .DIGIT_CYCLES (D),
        .GUARD_CYCLES (G),
        .LZ_BLANK     (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick),
        .digit_err  (digit_err)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic bit has_bad(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] exp_seg();
        int pos = m_t % FRAME;
        int i   = pos / SLOT;
        if (pos % SLOT < G) return 7'h7F;
        if (i > 0 && (m_disp >> (4 * i)) == 16'h0) return 7'h7F;
        return glyph(m_disp[4*i +: 4]);
    endfunction

    function automatic logic [3:0] exp_an();
        int pos = m_t % FRAME;
        if (pos % SLOT < G) return 4'hF;
        return 4'(~(32'd1 << (pos / SLOT)));
    endfunction

    // Apply one cycle of inputs and advance the model across the clock edge.
    task automatic step(input bit rst_n, input bit v, input logic [15:0] d);
        reset = rst_n; bcd_valid = v; bcd_in = d;
        @(posedge clk);
        if (!rst_n) begin
            m_t = 0; m_disp = '0; m_pend = '0; m_flag = 1'b0; m_err = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_err = has_bad(m_disp);
            m_t++;
            if (m_t % FRAME == 0 && m_flag) begin
                m_disp = m_pend;
                m_flag = 1'b0;
            end
            if (v) begin
                m_pend = d;
                m_flag = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_t % FRAME == pos) return;
            idle();
        end
        check("run_to_bound", 16'(m_t % FRAME), 16'(pos));
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", 16'(an), 16'(exp_an()));
            check("seg", 16'(seg), 16'(exp_seg()));
            check("dp", 16'(dp), 16'h1);
            check("frame_tick", 16'(frame_tick), 16'((m_t > 0) && (m_t % FRAME == 0)));
            check("digit_err", 16'(digit_err), 16'(m_err));
            check("an_single_low", 16'($countones(~an) <= 1), 16'h1);
            if (watch_one && seg == 7'b1111001) saw_one = 1'b1;
        end
    end

    initial begin
        int tick_at;
        int mode;
        logic [15:0] r;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0);
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_dp", 16'(dp), 16'h1);
        check("rst_tick", 16'(frame_tick), 16'h0);

        // First frame_tick 24 cycles after release
        tick_at = -1;
        for (int i = 1; i <= 100; i++) begin
            idle();
            if (frame_tick === 1'b1) begin
                tick_at = i;
                break;
            end
        end
        check("first_tick_latency", 16'(tick_at), 16'd24);

        // 1234 strobed mid-frame shows from the next frame
        run_to(8);
        step(1'b1, 1'b1, 16'h1234);
        run_to(2);
        check("d0_1234_seg", 16'(seg), 16'(7'b0011001));
        check("d0_1234_an", 16'(an), 16'(4'b1110));
        run_to(8);
        check("d1_1234_seg", 16'(seg), 16'(7'b0110000));
        check("d1_1234_an", 16'(an), 16'(4'b1101));
        run_to(14);
        check("d2_1234_seg", 16'(seg), 16'(7'b0100100));
        check("d2_1234_an", 16'(an), 16'(4'b1011));
        run_to(20);
        check("d3_1234_seg", 16'(seg), 16'(7'b1111001));
        check("d3_1234_an", 16'(an), 16'(4'b0111));

        // Leading-zero blanking
        step(1'b1, 1'b1, 16'h0007);
        run_to(2);
        check("d0_0007_seg", 16'(seg), 16'(7'b1111000));
        run_to(8);
        check("d1_0007_blank", 16'(seg), 16'h7F);
        check("d1_0007_an", 16'(an), 16'(4'b1101));
        step(1'b1, 1'b1, 16'h0000);
        run_to(2);
        check("d0_0000_seg", 16'(seg), 16'(7'b1000000));

        // Last strobe in a frame wins
        run_to(5);
        step(1'b1, 1'b1, 16'h1111);
        idle();
        step(1'b1, 1'b1, 16'h9999);
        saw_one = 1'b0;
        watch_one = 1'b1;
        run_to(2);
        check("d0_9999_seg", 16'(seg), 16'(7'b0010000));
        run_to(23);
        watch_one = 1'b0;
        check("no_1111_glyph", 16'(saw_one), 16'h0);

        // Invalid nibble: dash and digit_err
        run_to(10);
        step(1'b1, 1'b1, 16'h0A05);
        run_to(0);
        check("err_on_commit_edge", 16'(digit_err), 16'h0);
        idle();
        check("err_after_commit", 16'(digit_err), 16'h1);
        run_to(8);
        check("d1_0A05_zero", 16'(seg), 16'(7'b1000000));
        run_to(14);
        check("d2_0A05_dash", 16'(seg), 16'(7'b0111111));
        run_to(20);
        check("d3_0A05_blank", 16'(seg), 16'h7F);
        step(1'b1, 1'b1, 16'h0105);
        run_to(0);
        idle();
        check("err_cleared", 16'(digit_err), 16'h0);
        run_to(14);
        check("d2_0105_seg", 16'(seg), 16'(7'b1111001));

        // Reset during DRIVE of digit 2 with a value pending
        run_to(3);
        step(1'b1, 1'b1, 16'h4321);
        run_to(15);
        step(1'b0, 1'b0, 16'h0);
        check("mid_rst_an", 16'(an), 16'hF);
        check("mid_rst_seg", 16'(seg), 16'h7F);
        check("mid_rst_tick", 16'(frame_tick), 16'h0);
        check("mid_rst_err", 16'(digit_err), 16'h0);
        run_n(FRAME);
        run_to(2);
        check("post_rst_d0", 16'(seg), 16'(7'b1000000));
        run_to(8);
        check("post_rst_d1_blank", 16'(seg), 16'h7F);

        // Random strobes, values and occasional resets
        for (int c = 0; c < 1500; c++) begin
            mode = int'($urandom_range(0, 2));
            r = 16'($urandom);
            if (mode != 0) begin
                for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
                if (mode == 2) r = r >> (4 * $urandom_range(0, 3));
            end
            if ($urandom_range(0, 299) == 0)
                step(1'b0, 1'b0, 16'h0);
            else
                step(1'b1, $urandom_range(0, 29) == 0, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
